// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus a 2-bit counter PHT
// indexed by {global history, pc index}. Lookup is combinational and shows
// pre-update state; training happens on the clock edge from the resolve stage.
module branch_predictor #(
  parameter int         INDEX_BITS = 3,
  parameter int         BHR_BITS   = 2,
  parameter logic [1:0] PHT_RESET  = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [20:0] branch,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic [1:0]  upd_bhr,
  input  logic        upd_taken,
  input  logic [15:0] upd_target
);

  localparam int ENTRIES     = 1 << INDEX_BITS;
  localparam int TAG_BITS    = 15 - INDEX_BITS;
  localparam int PHT_BITS    = INDEX_BITS + BHR_BITS;
  localparam int PHT_ENTRIES = 1 << PHT_BITS;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken && ctr != 2'b11) result = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) result = ctr - 2'b01;
    return result;
  endfunction

  logic [1:0]          bhr_reg;
  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [15:0]         btb_target [ENTRIES];
  logic [1:0]          pht        [PHT_ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic [PHT_BITS-1:0]   upd_pht_idx;
  logic                  btb_wr;
  logic                  pht_wr;
  logic                  lk_hit;
  logic [1:0]            lk_ctr;

  // pc[0] never participates: instructions are halfword aligned.
  logic unused_lsb;
  assign unused_lsb = ^{pc[0], upd_pc[0]};

  assign lk_idx      = pc[INDEX_BITS:1];
  assign lk_tag      = pc[15:INDEX_BITS+1];
  assign upd_idx     = upd_pc[INDEX_BITS:1];
  assign upd_tag     = upd_pc[15:INDEX_BITS+1];
  // Training uses the history the branch was predicted with, not the live BHR.
  assign upd_pht_idx = {upd_bhr, upd_idx};
  // Only taken branches allocate/replace; not-taken leaves the BTB alone.
  assign btb_wr      = upd_valid && upd_taken;
  assign pht_wr      = upd_valid;

  genvar gi;

  // BTB entries: valid is reset, tag/target are plain enabled storage.
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_btb
      logic                valid_reg;
      logic [TAG_BITS-1:0] tag_reg;
      logic [15:0]         target_reg;

      // Direct-mapped replacement: a taken update always overwrites its slot.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
        end else if (btb_wr && upd_idx == INDEX_BITS'(gi)) begin
          valid_reg  <= 1'b1;
          tag_reg    <= upd_tag;
          target_reg <= upd_target;
        end
      end

      assign btb_valid[gi]  = valid_reg;
      assign btb_tag[gi]    = tag_reg;
      assign btb_target[gi] = target_reg;
    end
  endgenerate

  // PHT counters, one per {history, index} pair.
  generate
    for (gi = 0; gi < PHT_ENTRIES; gi++) begin : g_pht
      logic [1:0] ctr_reg;

      // Reset to weakly not-taken; otherwise step toward the actual outcome.
      always_ff @(posedge clk) begin
        if (reset) begin
          ctr_reg <= PHT_RESET;
        end else if (pht_wr && upd_pht_idx == PHT_BITS'(gi)) begin
          ctr_reg <= ctr_step(ctr_reg, upd_taken);
        end
      end

      assign pht[gi] = ctr_reg;
    end
  endgenerate

  // Global history shifts in each resolved outcome, and only then.
  always_ff @(posedge clk) begin
    if (reset) begin
      bhr_reg <= 2'b00;
    end else if (upd_valid) begin
      bhr_reg <= {bhr_reg[0], upd_taken};
    end
  end

  // Zero-latency lookup assembling the bundle {ctr, bhr, target, taken}.
  always_comb begin
    lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    lk_ctr = pht[{bhr_reg, lk_idx}];
    branch = {lk_ctr, bhr_reg, (lk_hit ? btb_target[lk_idx] : 16'h0000), (lk_hit & lk_ctr[1])};
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic, checked
// against an integer-arithmetic model of the BTB, PHT and history register.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [20:0] branch;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [1:0]  upd_bhr;
  logic        upd_taken;
  logic [15:0] upd_target;

  int checks = 0;
  int errors = 0;

  // Reference model state (8 BTB slots, 32 counters).
  bit m_valid  [8];
  int m_tag    [8];
  int m_target [8];
  int m_pht    [32];
  int m_bhr;

  branch_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .branch     (branch),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_bhr    (upd_bhr),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] model_lookup(input logic [15:0] p);
    int         idx;
    int         tag;
    int         c;
    bit         hit;
    logic [15:0] t;
    logic [1:0]  cb;
    logic [1:0]  bb;
    idx = (int'(p) / 2) % 8;
    tag = int'(p) / 16;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    c   = m_pht[m_bhr * 8 + idx];
    t   = hit ? 16'(m_target[idx]) : 16'h0000;
    cb  = 2'(c);
    bb  = 2'(m_bhr);
    return {cb, bb, t, (hit && c >= 2)};
  endfunction

  task automatic model_update(input bit rst, input bit uv, input logic [15:0] upc,
                              input logic [1:0] ub, input bit tk, input logic [15:0] tg);
    int idx;
    int pi;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 32; i++) m_pht[i] = 1;
      m_bhr = 0;
    end else if (uv) begin
      idx = (int'(upc) / 2) % 8;
      pi  = int'(ub) * 8 + idx;
      if (tk) m_pht[pi] = (m_pht[pi] < 3) ? m_pht[pi] + 1 : 3;
      else    m_pht[pi] = (m_pht[pi] > 0) ? m_pht[pi] - 1 : 0;
      if (tk) begin
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = int'(upc) / 16;
        m_target[idx] = int'(tg);
      end
      m_bhr = (m_bhr * 2 + (tk ? 1 : 0)) % 4;
    end
  endtask

  // One clock of traffic: drive, check the pre-edge lookup, clock, update model.
  task automatic step(input string tag, input bit do_check, input bit rst, input logic [15:0] p,
                      input bit uv, input logic [15:0] upc, input logic [1:0] ub,
                      input bit tk, input logic [15:0] tg);
    logic [20:0] exp;
    reset = rst;
    pc    = p;
    upd_valid = uv;
    if (uv) begin
      upd_pc = upc; upd_bhr = ub; upd_taken = tk; upd_target = tg;
    end else begin
      upd_pc = 'x; upd_bhr = 'x; upd_taken = 1'bx; upd_target = 'x;
    end
    #1;
    exp = model_lookup(p);
    if (do_check) check_eq(tag, branch, exp);
    $display("%-10s rst=%0b pc=%h upd=%0b upc=%h ubhr=%0d tk=%0b tgt=%h -> branch=%h exp=%h",
             tag, rst, p, uv, upc, ub, tk, tg, branch, exp);
    @(posedge clk);
    model_update(rst, uv, upc, ub, tk, tg);
    @(negedge clk);
  endtask

  // Lookup-only probe against a literal expected bundle, no clock advance.
  task automatic peek(input string tag, input logic [15:0] p, input logic [20:0] exp);
    reset = 1'b0;
    pc = p;
    upd_valid = 1'b0;
    #1;
    check_eq(tag, branch, exp);
    $display("%-10s pc=%h -> branch=%h exp=%h", tag, p, branch, exp);
  endtask

  initial begin
    logic [15:0] rp;
    logic [15:0] rupc;
    reset = 1'b1; pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_bhr = '0; upd_taken = 1'b0; upd_target = '0;
    @(negedge clk);

    // Reset: model state undefined before this edge, so no check this cycle.
    step("reset", 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);
    peek("rst_40", 16'h0040, 21'h080000);
    peek("rst_ffe", 16'hFFFE, 21'h080000);
    step("rst_look", 1'b1, 1'b0, 16'h0040, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);

    // Same-cycle hazard: lookup sees old state, next cycle sees the BTB entry.
    step("hazard", 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040, 2'd0, 1'b1, 16'h0100);
    step("post_upd", 1'b1, 1'b0, 16'h0040, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);

    // Saturation up then down on counter {00, idx 0}; BHR ends at 00.
    repeat (4) step("sat_up", 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040, 2'd0, 1'b1, 16'h0100);
    repeat (5) step("sat_dn", 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040, 2'd0, 1'b0, 16'h0100);
    peek("sat_floor", 16'h0040, 21'h000200);
    step("sat_look", 1'b1, 1'b0, 16'h0040, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);

    // Aliasing: 0x0050 shares slot 0 with 0x0040 and replaces it.
    step("alias_a", 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040, 2'd0, 1'b1, 16'h0100);
    step("alias_b", 1'b1, 1'b0, 16'h0050, 1'b1, 16'h0050, 2'd1, 1'b1, 16'h02A0);
    step("alias_40", 1'b1, 1'b0, 16'h0040, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);
    step("alias_50", 1'b1, 1'b0, 16'h0050, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0);

    // Reset wins over a concurrent taken update.
    step("rst_mid", 1'b1, 1'b1, 16'h0050, 1'b1, 16'h0050, 2'd3, 1'b1, 16'h0333);
    peek("rstm_40", 16'h0040, 21'h080000);
    peek("rstm_50", 16'h0050, 21'h080000);
    peek("rstm_123", 16'h1234, 21'h080000);

    // Random traffic over a few tags so hits, aliasing and saturation recur.
    for (int n = 0; n < 400; n++) begin
      rp   = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      rupc = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      step("rand", 1'b1, ($urandom_range(0, 63) == 0), rp,
           1'($urandom_range(0, 3) != 0), rupc, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
